// File: rtl/vram_rect_fill_if.sv
// Command + VRAM write-port bundle for the rectangle-fill engine.
// Pure wiring, no latency of its own.
// Backpressure rides on cmd_ready; the VRAM side has none (one write per WE cycle).
interface vram_rect_fill_if #(
    parameter int X_W    = 8,
    parameter int Y_W    = 7,
    parameter int ADDR_W = 15
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [X_W-1:0]    cmd_x;
    logic [Y_W-1:0]    cmd_y;
    logic [X_W-1:0]    cmd_w;
    logic [Y_W-1:0]    cmd_h;
    logic [11:0]       cmd_color;
    logic [ADDR_W-1:0] WAddr;
    logic [11:0]       Din;
    logic              WE;
    logic              busy;
    logic              done;

    // Command issuer and VRAM observer side
    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        input  cmd_ready, WAddr, Din, WE, busy, done
    );

    // Fill engine side
    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        output cmd_ready, WAddr, Din, WE, busy, done
    );
endinterface

// File: rtl/vram_rect_fill.sv
// Rectangle fill engine: clips a rectangle to the framebuffer and writes it in raster order.
// Latency: first WE two cycles after the handshake edge, then 1 pixel/clock, done one cycle after the last write.
// Backpressure: cmd_ready is high only in IDLE; cmd_valid is ignored while a command is in flight.
module vram_rect_fill #(
    parameter int H_RES  = 160,
    parameter int V_RES  = 120,
    parameter int X_W    = 8,
    parameter int Y_W    = 7,
    parameter int ADDR_W = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    vram_rect_fill_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_FILL  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [X_W:0]      H_RES_X = (X_W+1)'(H_RES);
    localparam logic [Y_W:0]      V_RES_Y = (Y_W+1)'(V_RES);
    localparam logic [ADDR_W-1:0] H_RES_A = ADDR_W'(H_RES);

    state_t            state_q;

    // Latched command
    logic [X_W-1:0]    x0_q;
    logic [Y_W-1:0]    y0_q;
    logic [X_W-1:0]    w_q;
    logic [Y_W-1:0]    h_q;
    logic [11:0]       color_q;

    // Walk state: (x_q, y_q) is the pixel currently presented on the write port
    logic [X_W-1:0]    x_q;
    logic [Y_W-1:0]    y_q;
    logic [X_W:0]      x_end_q;
    logic [Y_W:0]      y_end_q;
    logic [ADDR_W-1:0] row_base_q;

    // Registered outputs
    logic              cmd_ready_q;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [11:0]       din_q;
    logic              busy_q;
    logic              done_q;

    // Clip arithmetic used in SETUP; sums are one bit wider so they cannot wrap
    logic [X_W:0]      x_sum_d;
    logic [Y_W:0]      y_sum_d;
    logic [X_W:0]      x_end_d;
    logic [Y_W:0]      y_end_d;
    logic [ADDR_W-1:0] row_base_d;
    logic              empty_d;

    assign x_sum_d    = {1'b0, x0_q} + {1'b0, w_q};
    assign y_sum_d    = {1'b0, y0_q} + {1'b0, h_q};
    assign x_end_d    = (x_sum_d > H_RES_X) ? H_RES_X : x_sum_d;
    assign y_end_d    = (y_sum_d > V_RES_Y) ? V_RES_Y : y_sum_d;
    assign row_base_d = ADDR_W'(y0_q) * H_RES_A;
    assign empty_d    = (w_q == '0) || (h_q == '0) ||
                        ({1'b0, x0_q} >= H_RES_X) || ({1'b0, y0_q} >= V_RES_Y);

    // End-of-row / end-of-rectangle detection for the pixel currently being written
    logic              last_col;
    logic              last_row;
    logic [ADDR_W-1:0] next_row_base;

    assign last_col      = ({1'b0, x_q} == (x_end_q - (X_W+1)'(1)));
    assign last_row      = ({1'b0, y_q} == (y_end_q - (Y_W+1)'(1)));
    assign next_row_base = row_base_q + H_RES_A;

    // Control FSM with registered outputs; the next pixel is prepared one cycle ahead
    // so row wrap costs no bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            x0_q        <= '0;
            y0_q        <= '0;
            w_q         <= '0;
            h_q         <= '0;
            color_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            x_end_q     <= '0;
            y_end_q     <= '0;
            row_base_q  <= '0;
            cmd_ready_q <= 1'b1;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            din_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        x0_q        <= bus.cmd_x;
                        y0_q        <= bus.cmd_y;
                        w_q         <= bus.cmd_w;
                        h_q         <= bus.cmd_h;
                        color_q     <= bus.cmd_color;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    x_end_q    <= x_end_d;
                    y_end_q    <= y_end_d;
                    row_base_q <= row_base_d;
                    x_q        <= x0_q;
                    y_q        <= y0_q;
                    if (empty_d) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        // Present the top-left pixel straight away
                        we_q    <= 1'b1;
                        waddr_q <= row_base_d + ADDR_W'(x0_q);
                        din_q   <= color_q;
                        state_q <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (last_col && last_row) begin
                        we_q    <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (last_col) begin
                        x_q        <= x0_q;
                        y_q        <= y_q + Y_W'(1);
                        row_base_q <= next_row_base;
                        waddr_q    <= next_row_base + ADDR_W'(x0_q);
                    end else begin
                        x_q     <= x_q + X_W'(1);
                        waddr_q <= waddr_q + ADDR_W'(1);
                    end
                end
                S_DONE: begin
                    done_q      <= 1'b0;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.WE        = we_q;
    assign bus.WAddr     = waddr_q;
    assign bus.Din       = din_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_vram_rect_fill.sv
// Directed bench for vram_rect_fill: reset, basic fill, clipping, degenerate commands,
// full clear, backpressure and reset mid-fill. Outputs are sampled on the falling edge.
module tb_vram_rect_fill;

    logic clk;
    logic rst_n;

    vram_rect_fill_if #(.X_W(8), .Y_W(7), .ADDR_W(15)) bus ();

    vram_rect_fill #(
        .H_RES(160), .V_RES(120), .X_W(8), .Y_W(7), .ADDR_W(15)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_fail;

    // Observations gathered after a command; cycle k means "k cycles after the handshake edge"
    int          wr_addr[$];
    logic [11:0] wr_din[$];
    int          wr_cyc[$];
    int          done_cyc;
    int          ready_hi;

    // Present one command at a falling edge; the next rising edge is the handshake edge.
    task automatic issue(input int x, input int y, input int w, input int h, input logic [11:0] c);
        @(negedge clk);
        bus.cmd_x     = 8'(x);
        bus.cmd_y     = 7'(y);
        bus.cmd_w     = 8'(w);
        bus.cmd_h     = 7'(h);
        bus.cmd_color = c;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    // Record writes until done or until the cycle budget runs out (done_cyc stays -1).
    task automatic collect(input int limit);
        wr_addr.delete();
        wr_din.delete();
        wr_cyc.delete();
        done_cyc = -1;
        ready_hi = 0;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (bus.cmd_ready) ready_hi++;
            if (bus.WE) begin
                wr_addr.push_back(int'(bus.WAddr));
                wr_din.push_back(bus.Din);
                wr_cyc.push_back(k);
            end
            if (bus.done) begin
                done_cyc = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready); end
        n_cmp++; if (bus.WE !== 1'b0)        begin n_fail++; $display("FAIL reset_we: got %b expected 0", bus.WE); end
        n_cmp++; if (bus.WAddr !== 15'd0)    begin n_fail++; $display("FAIL reset_waddr: got %0d expected 0", bus.WAddr); end
        n_cmp++; if (bus.Din !== 12'h000)    begin n_fail++; $display("FAIL reset_din: got %h expected 000", bus.Din); end
        n_cmp++; if (bus.busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0)      begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        // (3,1) 2x2: rows 1 and 2 -> 160+3, 160+4, 320+3, 320+4
        int exp_a[4] = '{163, 164, 323, 324};
        issue(3, 1, 2, 2, 12'hF00);
        collect(20);
        n_cmp++; if (wr_addr.size() !== 4) begin n_fail++; $display("FAIL basic_count: got %0d expected 4", wr_addr.size()); end
        for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
            n_cmp++; if (wr_addr[i] !== exp_a[i]) begin n_fail++; $display("FAIL basic_addr[%0d]: got %0d expected %0d", i, wr_addr[i], exp_a[i]); end
            n_cmp++; if (wr_din[i] !== 12'hF00)   begin n_fail++; $display("FAIL basic_din[%0d]: got %h expected F00", i, wr_din[i]); end
            n_cmp++; if (wr_cyc[i] !== i + 2)     begin n_fail++; $display("FAIL basic_cycle[%0d]: got %0d expected %0d", i, wr_cyc[i], i + 2); end
        end
        n_cmp++; if (done_cyc !== 6) begin n_fail++; $display("FAIL basic_done_cycle: got %0d expected 6", done_cyc); end
        n_cmp++; if (ready_hi !== 0) begin n_fail++; $display("FAIL basic_ready_while_busy: got %0d cycles expected 0", ready_hi); end
        @(negedge clk);
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_after: got %b expected 1", bus.cmd_ready); end
        n_cmp++; if (bus.done !== 1'b0)      begin n_fail++; $display("FAIL basic_done_width: got %b expected 0", bus.done); end
        n_cmp++; if (bus.busy !== 1'b0)      begin n_fail++; $display("FAIL basic_busy_after: got %b expected 0", bus.busy); end
    endtask

    task automatic test_corner_clip();
        int over;
        // Visible part is x 158..159 on row 119: 119*160 = 19040 -> 19198, 19199
        issue(158, 119, 5, 3, 12'h0F0);
        collect(30);
        over = 0;
        foreach (wr_addr[i]) if (wr_addr[i] >= 19200) over++;
        n_cmp++; if (wr_addr.size() !== 2) begin n_fail++; $display("FAIL clip_count: got %0d expected 2", wr_addr.size()); end
        if (wr_addr.size() >= 2) begin
            n_cmp++; if (wr_addr[0] !== 19198) begin n_fail++; $display("FAIL clip_addr0: got %0d expected 19198", wr_addr[0]); end
            n_cmp++; if (wr_addr[1] !== 19199) begin n_fail++; $display("FAIL clip_addr1: got %0d expected 19199", wr_addr[1]); end
            n_cmp++; if (wr_din[1] !== 12'h0F0) begin n_fail++; $display("FAIL clip_din: got %h expected 0F0", wr_din[1]); end
        end
        n_cmp++; if (over !== 0)     begin n_fail++; $display("FAIL clip_out_of_range: got %0d writes expected 0", over); end
        n_cmp++; if (done_cyc !== 4) begin n_fail++; $display("FAIL clip_done_cycle: got %0d expected 4", done_cyc); end
        @(negedge clk);
    endtask

    task automatic test_degenerate();
        int dx[3] = '{5, 200, 5};
        int dy[3] = '{5, 5, 120};
        int dw[3] = '{0, 10, 4};
        int dh[3] = '{3, 3, 3};
        for (int c = 0; c < 3; c++) begin
            issue(dx[c], dy[c], dw[c], dh[c], 12'hABC);
            collect(10);
            n_cmp++; if (wr_addr.size() !== 0) begin n_fail++; $display("FAIL degen%0d_writes: got %0d expected 0", c, wr_addr.size()); end
            n_cmp++; if (done_cyc !== 2)       begin n_fail++; $display("FAIL degen%0d_done_cycle: got %0d expected 2", c, done_cyc); end
            @(negedge clk);
            n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL degen%0d_ready_after: got %b expected 1", c, bus.cmd_ready); end
        end
    endtask

    task automatic test_full_clear();
        int bad_addr;
        int bad_cyc;
        issue(0, 0, 160, 120, 12'h000);
        collect(19300);
        bad_addr = 0;
        bad_cyc  = 0;
        foreach (wr_addr[i]) begin
            if (wr_addr[i] !== i)    bad_addr++;
            if (wr_cyc[i] !== i + 2) bad_cyc++;
        end
        n_cmp++; if (wr_addr.size() !== 19200) begin n_fail++; $display("FAIL clear_count: got %0d expected 19200", wr_addr.size()); end
        n_cmp++; if (bad_addr !== 0)           begin n_fail++; $display("FAIL clear_sequence: got %0d bad addresses expected 0", bad_addr); end
        n_cmp++; if (bad_cyc !== 0)            begin n_fail++; $display("FAIL clear_contiguous: got %0d gaps expected 0", bad_cyc); end
        n_cmp++; if (done_cyc !== 19202)       begin n_fail++; $display("FAIL clear_done_cycle: got %0d expected 19202", done_cyc); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int exp_a;
        // First command 4x3 at (10,20) colour 00F; second 2x1 at (0,0) colour ABC held on the bus throughout
        @(negedge clk);
        bus.cmd_x = 8'd10; bus.cmd_y = 7'd20; bus.cmd_w = 8'd4; bus.cmd_h = 7'd3;
        bus.cmd_color = 12'h00F;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_x = 8'd0; bus.cmd_y = 7'd0; bus.cmd_w = 8'd2; bus.cmd_h = 7'd1;
        bus.cmd_color = 12'hABC;
        collect(30);
        n_cmp++; if (wr_addr.size() !== 12) begin n_fail++; $display("FAIL bp_first_count: got %0d expected 12", wr_addr.size()); end
        for (int i = 0; i < 12 && i < wr_addr.size(); i++) begin
            // row 20 starts at 3200; rows are 3210.., 3370.., 3530..
            exp_a = 3210 + (i / 4) * 160 + (i % 4);
            n_cmp++; if (wr_addr[i] !== exp_a || wr_din[i] !== 12'h00F) begin
                n_fail++; $display("FAIL bp_first_write[%0d]: got %0d/%h expected %0d/00F", i, wr_addr[i], wr_din[i], exp_a);
            end
        end
        n_cmp++; if (ready_hi !== 0)  begin n_fail++; $display("FAIL bp_ready_low: got %0d high cycles expected 0", ready_hi); end
        n_cmp++; if (done_cyc !== 14) begin n_fail++; $display("FAIL bp_first_done: got %0d expected 14", done_cyc); end
        @(negedge clk);
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL bp_first_idle_ready: got %b expected 1", bus.cmd_ready); end
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        collect(10);
        n_cmp++; if (wr_addr.size() !== 2) begin n_fail++; $display("FAIL bp_second_count: got %0d expected 2", wr_addr.size()); end
        if (wr_addr.size() >= 2) begin
            n_cmp++; if (wr_addr[0] !== 0 || wr_addr[1] !== 1) begin n_fail++; $display("FAIL bp_second_addr: got %0d,%0d expected 0,1", wr_addr[0], wr_addr[1]); end
            n_cmp++; if (wr_din[0] !== 12'hABC) begin n_fail++; $display("FAIL bp_second_din: got %h expected ABC", wr_din[0]); end
        end
        n_cmp++; if (done_cyc !== 4) begin n_fail++; $display("FAIL bp_second_done: got %0d expected 4", done_cyc); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_fill();
        int extra_done;
        int extra_we;
        issue(0, 0, 10, 10, 12'h123);
        repeat (6) @(negedge clk);
        // cycle t+6 carries the 5th write, address 4
        n_cmp++; if (bus.WE !== 1'b1 || bus.WAddr !== 15'd4) begin n_fail++; $display("FAIL rst_mid_fifth_write: got WE=%b addr=%0d expected WE=1 addr=4", bus.WE, bus.WAddr); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++; if (bus.WE !== 1'b0)        begin n_fail++; $display("FAIL rst_mid_we: got %b expected 0", bus.WE); end
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b expected 1", bus.cmd_ready); end
        n_cmp++; if (bus.busy !== 1'b0)      begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", bus.busy); end
        n_cmp++; if (bus.WAddr !== 15'd0 || bus.Din !== 12'h000) begin n_fail++; $display("FAIL rst_mid_bus: got addr=%0d din=%h expected 0/000", bus.WAddr, bus.Din); end
        extra_done = 0;
        extra_we   = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (bus.done) extra_done++;
            if (bus.WE)   extra_we++;
        end
        n_cmp++; if (extra_done !== 0) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d pulses expected 0", extra_done); end
        n_cmp++; if (extra_we !== 0)   begin n_fail++; $display("FAIL rst_mid_no_we: got %0d writes expected 0", extra_we); end
        issue(1, 1, 1, 1, 12'h555);
        collect(10);
        n_cmp++; if (wr_addr.size() !== 1) begin n_fail++; $display("FAIL rst_after_count: got %0d expected 1", wr_addr.size()); end
        if (wr_addr.size() >= 1) begin
            n_cmp++; if (wr_addr[0] !== 161 || wr_din[0] !== 12'h555) begin n_fail++; $display("FAIL rst_after_write: got %0d/%h expected 161/555", wr_addr[0], wr_din[0]); end
        end
        n_cmp++; if (done_cyc !== 3) begin n_fail++; $display("FAIL rst_after_done: got %0d expected 3", done_cyc); end
        @(negedge clk);
    endtask

    initial begin
        n_cmp         = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_x     = '0;
        bus.cmd_y     = '0;
        bus.cmd_w     = '0;
        bus.cmd_h     = '0;
        bus.cmd_color = '0;
        test_reset();
        test_basic();
        test_corner_clip();
        test_degenerate();
        test_full_clear();
        test_back_to_back();
        test_reset_mid_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
